// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module     : spi_reg_bank
// Description: Register bank and command decoder downstream of spi_slave.
//              Turns each SPI transaction (command byte followed by data bytes)
//              into register reads/writes and supplies the next MISO byte.
//              Command byte: bit7 = 1 write / 0 read, bits[6:0] = address.
//              Optional feature macro: SPI_REG_AUTOINC_EN (burst address
//              auto-increment after every data byte; default build holds addr).
// Revision   : 1.0 - initial release
// ============================================================================
module spi_reg_bank #(
  parameter logic [7:0] FW_VERSION     = 8'hC3,
  parameter logic       BOOT_FORCE_RST = 1'b0,
  parameter logic [7:0] SCRATCH_RST    = 8'h00
) (
  input  logic       i_clk_core,
  input  logic       i_reset_n,
  input  logic       i_transaction_begin,
  input  logic       i_rx_byte_available,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_tx_byte,
  output logic       o_boot_force,
  output logic [7:0] o_scratch,
  output logic       o_wr_strobe,
  output logic [6:0] o_wr_addr
);

  localparam logic [6:0] c_ADDR_VERSION = 7'h00;
  localparam logic [6:0] c_ADDR_BOOT    = 7'h01;
  localparam logic [6:0] c_ADDR_SCRATCH = 7'h02;
  localparam logic [6:0] c_ADDR_ERR     = 7'h03;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_av_hist;
  logic       r_is_wr;
  logic [6:0] r_addr;
  logic [7:0] r_tx_byte;
  logic       r_boot_force;
  logic [7:0] r_scratch;
  logic [7:0] r_err_count;
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;

  logic       w_byte_evt;
  logic [6:0] w_addr_next;

  // A new byte is the first cycle the history shows available low->high.
  assign w_byte_evt = (r_av_hist == 2'b01);

`ifdef SPI_REG_AUTOINC_EN
  // Burst mode: each data byte moves to the next address (7-bit wrap).
  assign w_addr_next = r_addr + 7'd1;
`else
  // Fixed mode: every data byte targets the command's address.
  assign w_addr_next = r_addr;
`endif

  // Read view of the register map; unmapped addresses read zero.
  function automatic logic [7:0] f_reg_read(input logic [6:0] addr,
                                             input logic       boot,
                                             input logic [7:0] scratch,
                                             input logic [7:0] errs);
    case (addr)
      c_ADDR_VERSION: f_reg_read = FW_VERSION;
      c_ADDR_BOOT:    f_reg_read = {7'b0, boot};
      c_ADDR_SCRATCH: f_reg_read = scratch;
      c_ADDR_ERR:     f_reg_read = errs;
      default:        f_reg_read = 8'h00;
    endcase
  endfunction

  // Edge detect, transaction FSM, register writes and MISO byte selection.
  always_ff @(posedge i_clk_core or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_av_hist    <= 2'b00;
      r_is_wr      <= 1'b0;
      r_addr       <= 7'h00;
      r_tx_byte    <= 8'h00;
      r_boot_force <= BOOT_FORCE_RST;
      r_scratch    <= SCRATCH_RST;
      r_err_count  <= 8'h00;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= 7'h00;
    end else begin
      r_av_hist   <= {r_av_hist[0], i_rx_byte_available};
      r_wr_strobe <= 1'b0;
      if (i_transaction_begin) begin
        // Begin has priority: any byte arriving this cycle is discarded.
        r_state   <= S_CMD;
        r_tx_byte <= 8'h00;
      end else if (w_byte_evt) begin
        case (r_state)
          S_CMD: begin
            r_is_wr <= i_rx_byte[7];
            r_addr  <= i_rx_byte[6:0];
            r_state <= S_DATA;
            if (!i_rx_byte[7]) begin
              r_tx_byte <= f_reg_read(i_rx_byte[6:0], r_boot_force,
                                      r_scratch, r_err_count);
            end
          end
          S_DATA: begin
            if (r_is_wr) begin
              case (r_addr)
                c_ADDR_BOOT: begin
                  r_boot_force <= i_rx_byte[0];
                  r_wr_strobe  <= 1'b1;
                  r_wr_addr    <= r_addr;
                end
                c_ADDR_SCRATCH: begin
                  r_scratch   <= i_rx_byte;
                  r_wr_strobe <= 1'b1;
                  r_wr_addr   <= r_addr;
                end
                default: begin
                  // Read-only or unmapped target: drop and count, saturating.
                  if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                  end
                end
              endcase
            end else begin
              r_tx_byte <= f_reg_read(w_addr_next, r_boot_force,
                                      r_scratch, r_err_count);
            end
            r_addr <= w_addr_next;
          end
          default: begin
            // Bytes outside a transaction are ignored.
          end
        endcase
      end
    end
  end

  assign o_tx_byte    = r_tx_byte;
  assign o_boot_force = r_boot_force;
  assign o_scratch    = r_scratch;
  assign o_wr_strobe  = r_wr_strobe;
  assign o_wr_addr    = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module     : tb_spi_reg_bank
// Description: Randomized self-checking bench for spi_reg_bank against a
//              transaction-level register model. Honours SPI_REG_AUTOINC_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

  localparam logic [7:0] c_VERSION = 8'hC3;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit c_AUTOINC = 1'b1;
`else
  localparam bit c_AUTOINC = 1'b0;
`endif

  logic       r_clk   = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       r_begin = 1'b0;
  logic       r_avail = 1'b0;
  logic [7:0] r_rxb   = 8'h00;
  logic [7:0] w_tx_byte;
  logic       w_boot_force;
  logic [7:0] w_scratch;
  logic       w_wr_strobe;
  logic [6:0] w_wr_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (transaction level).
  bit         m_boot;
  logic [7:0] m_scratch;
  int         m_err;
  int         m_phase;      // 0 idle, 1 expecting command, 2 data bytes
  bit         m_wr;
  int         m_addr;
  logic [7:0] m_tx;
  int         m_strobes;
  logic [6:0] m_wr_addr;
  int         seen_strobes = 0;

  spi_reg_bank #(
    .FW_VERSION    (c_VERSION),
    .BOOT_FORCE_RST(1'b0),
    .SCRATCH_RST   (8'h00)
  ) u_dut (
    .i_clk_core         (r_clk),
    .i_reset_n          (r_rst_n),
    .i_transaction_begin(r_begin),
    .i_rx_byte_available(r_avail),
    .i_rx_byte          (r_rxb),
    .o_tx_byte          (w_tx_byte),
    .o_boot_force       (w_boot_force),
    .o_scratch          (w_scratch),
    .o_wr_strobe        (w_wr_strobe),
    .o_wr_addr          (w_wr_addr)
  );

  always #10 r_clk = ~r_clk;

  // Every cycle the strobe is seen high counts once; a stretched pulse over-counts.
  always @(negedge r_clk) if (r_rst_n && w_wr_strobe) seen_strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    case (a)
      0:       m_read = c_VERSION;
      1:       m_read = {7'b0, m_boot};
      2:       m_read = m_scratch;
      3:       m_read = m_err[7:0];
      default: m_read = 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_boot = 1'b0; m_scratch = 8'h00; m_err = 0; m_phase = 0;
    m_wr = 1'b0; m_addr = 0; m_tx = 8'h00; m_wr_addr = 7'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".tx"},      w_tx_byte,    m_tx);
    check({tag, ".boot"},    w_boot_force, m_boot);
    check({tag, ".scratch"}, w_scratch,    m_scratch);
    check({tag, ".strobes"}, seen_strobes, m_strobes);
    check({tag, ".wr_addr"}, w_wr_addr,    m_wr_addr);
  endtask

  task automatic do_begin();
    @(negedge r_clk); r_begin = 1'b1;
    @(negedge r_clk); r_begin = 1'b0;
    m_phase = 1; m_tx = 8'h00;
    check("begin.tx", w_tx_byte, 8'h00);
  endtask

  // Present one byte; optionally raise transaction_begin in the byte's decode cycle.
  task automatic send_byte(input logic [7:0] b, input bit coincide);
    @(negedge r_clk); r_rxb = b; r_avail = 1'b1;
    if (coincide) begin
      @(negedge r_clk); r_begin = 1'b1;
      @(negedge r_clk); r_begin = 1'b0;
    end
    repeat (3) @(posedge r_clk);
    #1;
    if (coincide) begin
      m_phase = 1; m_tx = 8'h00;
    end else if (m_phase == 1) begin
      m_wr = b[7]; m_addr = int'(b[6:0]); m_phase = 2;
      if (!m_wr) m_tx = m_read(m_addr);
    end else if (m_phase == 2) begin
      if (m_wr) begin
        if (m_addr == 1 || m_addr == 2) begin
          if (m_addr == 1) m_boot = b[0]; else m_scratch = b;
          m_strobes++; m_wr_addr = 7'(m_addr);
        end else if (m_err < 255) begin
          m_err++;
        end
        if (c_AUTOINC) m_addr = (m_addr + 1) % 128;
      end else begin
        if (c_AUTOINC) m_addr = (m_addr + 1) % 128;
        m_tx = m_read(m_addr);
      end
    end
    check_outputs(coincide ? "byte_begin" : "byte");
    @(negedge r_clk); r_avail = 1'b0;
    repeat (2) @(negedge r_clk);
  endtask

  task automatic read_reg(input logic [6:0] a, input logic [7:0] exp, input string tag);
    do_begin();
    send_byte({1'b0, a}, 1'b0);
    check(tag, w_tx_byte, exp);
  endtask

  initial begin
    model_reset();
    m_strobes = 0;
    repeat (3) @(negedge r_clk);
    check("rst.tx", w_tx_byte, 8'h00);
    check("rst.boot", w_boot_force, 1'b0);
    check("rst.scratch", w_scratch, 8'h00);
    check("rst.wr_strobe", w_wr_strobe, 1'b0);
    check("rst.wr_addr", w_wr_addr, 7'h00);
    r_rst_n = 1'b1;
    repeat (2) @(negedge r_clk);

    // Byte in IDLE has no effect.
    send_byte(8'h82, 1'b0);
    send_byte(8'h55, 1'b0);

    // Version read.
    read_reg(7'h00, 8'hC3, "t1.version");

    // Boot force write then read back.
    do_begin();
    send_byte(8'h81, 1'b0);
    send_byte(8'h01, 1'b0);
    check("t2.boot", w_boot_force, 1'b1);
    check("t2.wr_addr", w_wr_addr, 7'h01);
    read_reg(7'h01, 8'h01, "t2.readback");

    // Two-byte write from scratch.
    do_begin();
    send_byte(8'h82, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("t3.scratch", w_scratch, c_AUTOINC ? 8'hA5 : 8'h5A);
    read_reg(7'h03, c_AUTOINC ? 8'h01 : 8'h00, "t3.err_count");

    // Read burst starting at the top address.
    do_begin();
    send_byte(8'h7F, 1'b0);
    check("t6.first", w_tx_byte, 8'h00);
    send_byte(8'hEE, 1'b0);
    check("t6.second", w_tx_byte, c_AUTOINC ? 8'hC3 : 8'h00);

    // Error counter saturation via writes to the read-only version register.
    for (int i = 0; i < 300; i++) begin
      do_begin();
      send_byte(8'h80, 1'b0);
      send_byte(8'($urandom), 1'b0);
    end
    read_reg(7'h03, 8'hFF, "t4.err_sat");
    read_reg(7'h00, 8'hC3, "t4.version");

    // Randomized transactions, occasionally colliding begin with a byte.
    for (int t = 0; t < 40; t++) begin
      int sel;
      int nb;
      logic [6:0] a;
      sel = int'($urandom_range(0, 5));
      a = (sel < 4) ? 7'(sel) : (sel == 4 ? 7'($urandom) : 7'h7F);
      do_begin();
      send_byte({1'($urandom), a}, 1'b0);
      nb = int'($urandom_range(0, 4));
      for (int k = 0; k < nb; k++) begin
        send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    // Begin colliding with a command byte: byte lost, next byte is the command.
    do_begin();
    send_byte(8'h82, 1'b1);
    send_byte(8'h02, 1'b0);
    check("t5.collide_read", w_tx_byte, m_read(2));

    // Asynchronous reset in the middle of a write burst.
    do_begin();
    send_byte(8'h82, 1'b0);
    send_byte(8'h3C, 1'b0);
    @(negedge r_clk); r_rxb = 8'hC7; r_avail = 1'b1;
    #3 r_rst_n = 1'b0;
    #1;
    model_reset();
    check("t5.rst.tx", w_tx_byte, 8'h00);
    check("t5.rst.boot", w_boot_force, 1'b0);
    check("t5.rst.scratch", w_scratch, 8'h00);
    check("t5.rst.wr_strobe", w_wr_strobe, 1'b0);
    check("t5.rst.wr_addr", w_wr_addr, 7'h00);
    r_avail = 1'b0;
    repeat (3) @(negedge r_clk);
    r_rst_n = 1'b1;
    repeat (2) @(negedge r_clk);
    send_byte(8'h81, 1'b0);
    read_reg(7'h03, 8'h00, "t5.err_cleared");
    read_reg(7'h00, 8'hC3, "t5.version_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
